press_decoder: RTL and testbench

PRESS_DECODER -- requirements
Module: press_decoder

---
 rtl/press_decoder.sv | 102 ++++++++++
 tb/tb_press_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/press_decoder.sv
// press_decoder: classifies a debounced key into short/long presses; auto-repeat enabled by PRESS_DECODER_REPEAT_EN
module press_decoder #(
  parameter logic [15:0] LONG_CYCLES   = 16'd1000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_hold_cnt, w_hold_nxt;
  logic        r_short, r_long, r_held;
  logic        w_short_nxt, w_long_nxt;
  logic [7:0]  r_press_cnt;
`ifdef PRESS_DECODER_REPEAT_EN
  logic [15:0] r_rpt_cnt, w_rpt_cnt_nxt;
  logic        r_rpt, w_rpt_nxt;
`endif
  // next-state and pulse decode; release takes priority over the long threshold
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
`ifdef PRESS_DECODER_REPEAT_EN
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_rpt_nxt     = 1'b0;
`endif
    case (r_state)
      IDLE: if (in) begin
        w_state_nxt = PRESSED;
        w_hold_nxt  = 16'd0;
      end
      PRESSED: if (!in) begin
        w_state_nxt = IDLE;
        w_short_nxt = 1'b1;
      end else if (r_hold_cnt == LONG_CYCLES - 16'd1) begin
        w_state_nxt = LONG;
        w_long_nxt  = 1'b1;
`ifdef PRESS_DECODER_REPEAT_EN
        w_rpt_cnt_nxt = 16'd0;
`endif
      end else begin
        w_hold_nxt = r_hold_cnt + 16'd1;
      end
      LONG: if (!in) begin
        w_state_nxt = IDLE;
`ifdef PRESS_DECODER_REPEAT_EN
      end else if (r_rpt_cnt == REPEAT_CYCLES - 16'd1) begin
        w_rpt_cnt_nxt = 16'd0;
        w_rpt_nxt     = 1'b1;
      end else begin
        w_rpt_cnt_nxt = r_rpt_cnt + 16'd1;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state, counters and registered outputs; held mirrors the state being left non-IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold_cnt  <= 16'd0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_held      <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_held      <= (w_state_nxt != IDLE);
      r_press_cnt <= r_press_cnt + {7'd0, w_short_nxt | w_long_nxt};
    end
  end
`ifdef PRESS_DECODER_REPEAT_EN
  // auto-repeat period counter and pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rpt_cnt <= 16'd0;
      r_rpt     <= 1'b0;
    end else begin
      r_rpt_cnt <= w_rpt_cnt_nxt;
      r_rpt     <= w_rpt_nxt;
    end
  end
  assign repeat_pulse = r_rpt;
`else
  assign repeat_pulse = 1'b0;
`endif
  assign short_press = r_short;
  assign long_press  = r_long;
  assign held        = r_held;
  assign press_cnt   = r_press_cnt;
endmodule

// File: tb/tb_press_decoder.sv
// tb_press_decoder: table-driven press-length vectors plus reset and wrap sequences (LONG_CYCLES=10, REPEAT_CYCLES=4)
module tb_press_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       short_press, long_press, repeat_pulse, held;
  logic [7:0] press_cnt;
  int n_pass = 0, n_total = 0;
  int o_short, o_long, o_rpt, o_held, o_short_at, o_long_at, o_overlap;
  int exp_cnt, tot_short;
`ifdef PRESS_DECODER_REPEAT_EN
  localparam int RPT_ON = 1;
`else
  localparam int RPT_ON = 0;
`endif
  typedef struct {int n; int s; int s_at; int l; int l_at; int rpt;} vec_t;
  vec_t v[7];

  press_decoder #(.LONG_CYCLES(16'd10), .REPEAT_CYCLES(16'd4)) dut (
    .clk(clk), .reset(reset), .in(in),
    .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse),
    .held(held), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_obs();
    o_short = 0; o_long = 0; o_rpt = 0; o_held = 0;
    o_short_at = 0; o_long_at = 0; o_overlap = 0;
  endtask

  task automatic observe(input int i);
    @(posedge clk);
    #1;
    if (short_press) begin o_short++; o_short_at = i; end
    if (long_press) begin o_long++; o_long_at = i; end
    if (repeat_pulse) o_rpt++;
    if (held) o_held++;
    if (int'(short_press) + int'(long_press) + int'(repeat_pulse) > 1) o_overlap++;
  endtask

  task automatic run_press(input int n, input int tail);
    clear_obs();
    for (int i = 1; i <= n + tail; i++) begin
      in = (i <= n);
      observe(i);
    end
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_short"}, int'(short_press), 0);
    check({tag, "_long"}, int'(long_press), 0);
    check({tag, "_rpt"}, int'(repeat_pulse), 0);
    check({tag, "_held"}, int'(held), 0);
    check({tag, "_cnt"}, int'(press_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{1, 1, 2, 0, 0, 0};
    v[1] = '{5, 1, 6, 0, 0, 0};
    v[2] = '{9, 1, 10, 0, 0, 0};
    v[3] = '{10, 1, 11, 0, 0, 0};
    v[4] = '{11, 0, 0, 1, 11, 0};
    v[5] = '{15, 0, 0, 1, 11, RPT_ON};
    v[6] = '{23, 0, 0, 1, 11, 3 * RPT_ON};
    #12;
    check_clear("reset");
    reset = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      run_press(v[k].n, 4);
      exp_cnt = (exp_cnt + v[k].s + v[k].l) % 256;
      check($sformatf("v%0d_short", k), o_short, v[k].s);
      check($sformatf("v%0d_short_at", k), o_short_at, v[k].s_at);
      check($sformatf("v%0d_long", k), o_long, v[k].l);
      check($sformatf("v%0d_long_at", k), o_long_at, v[k].l_at);
      check($sformatf("v%0d_rpt", k), o_rpt, v[k].rpt);
      check($sformatf("v%0d_held", k), o_held, v[k].n);
      check($sformatf("v%0d_cnt", k), int'(press_cnt), exp_cnt);
      check($sformatf("v%0d_overlap", k), o_overlap, 0);
    end
    clear_obs();
    for (int i = 1; i <= 6; i++) begin
      in = 1'b1;
      observe(i);
    end
    check("mid_held_before", int'(held), 1);
    #2;
    reset = 1'b1;
    #1;
    check_clear("async_reset");
    check("mid_no_pulse", o_short + o_long, 0);
    #1;
    reset = 1'b0;
    clear_obs();
    for (int i = 1; i <= 15; i++) begin
      in = (i <= 11);
      observe(i);
    end
    check("rst_press_long", o_long, 1);
    check("rst_press_long_at", o_long_at, 11);
    check("rst_press_short", o_short, 0);
    check("rst_press_held", o_held, 11);
    check("rst_press_cnt", int'(press_cnt), 1);
    #3;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tot_short = 0;
    for (int k = 0; k < 256; k++) begin
      run_press(1, 1);
      tot_short += o_short;
    end
    check("wrap_shorts", tot_short, 256);
    check("wrap_cnt", int'(press_cnt), 0);
    run_press(1, 1);
    check("wrap_cnt_plus1", int'(press_cnt), 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
